// File: rtl/multi_channel_pwm.sv
// Multi-channel PWM generator: one prescaled timebase shared by all channels,
// edge- or center-aligned, with period/mode/duty double-buffered to period boundaries.
module multi_channel_pwm #(
    parameter int unsigned RESOLUTION     = 8,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned CHAN_BITS      = 2,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [RESOLUTION-1:0]     period,
    input  logic                      wr_en,
    input  logic [CHAN_BITS-1:0]      wr_chan,
    input  logic [RESOLUTION-1:0]     wr_duty,
    output logic [CHANNELS-1:0]       pulse,
    output logic [RESOLUTION-1:0]     counter,
    output logic                      period_start
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    dir_t                      dir;
    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic [RESOLUTION-1:0]     active_period;
    logic                      active_mode;
    logic [RESOLUTION-1:0]     pending_duty [CHANNELS];
    logic [RESOLUTION-1:0]     active_duty  [CHANNELS];
    logic                      tick;
    logic                      at_top;
    logic                      boundary;
    logic [CHANNELS-1:0]       compare;

    assign tick   = enable && (prescaler >= prescale);
    assign at_top = counter >= active_period;

    // Boundary = the tick on which the counter returns to 0 and shadows reload.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (active_period == '0)
                boundary = 1'b1;
            else if (!active_mode)
                boundary = at_top;
            else if (dir == UP)
                boundary = at_top && (active_period == RESOLUTION'(1));
            else
                boundary = counter <= RESOLUTION'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++)
            compare[i] = (active_duty[i] != '0) && (counter < active_duty[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(CHANNELS); i++)
                pending_duty[i] <= '0;
        end else if (wr_en && (32'(wr_chan) < CHANNELS)) begin
            pending_duty[wr_chan] <= wr_duty;
        end
    end

    // Timebase FSM, shadow registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir           <= UP;
            prescaler     <= '0;
            counter       <= '0;
            active_period <= '0;
            active_mode   <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++)
                active_duty[i] <= '0;
            pulse         <= '0;
            period_start  <= 1'b0;
        end else if (!enable) begin
            dir           <= UP;
            prescaler     <= '0;
            counter       <= '0;
            active_period <= period;
            active_mode   <= mode;
            for (int i = 0; i < int'(CHANNELS); i++)
                active_duty[i] <= pending_duty[i];
            pulse         <= '0;
            period_start  <= 1'b0;
        end else begin
            pulse        <= compare;
            period_start <= boundary;
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (boundary) begin
                counter       <= '0;
                dir           <= UP;
                active_period <= period;
                active_mode   <= mode;
                for (int i = 0; i < int'(CHANNELS); i++)
                    active_duty[i] <= pending_duty[i];
            end else if (tick) begin
                case (dir)
                    UP: begin
                        if (active_mode && at_top) begin
                            counter <= active_period - 1'b1;
                            dir     <= DOWN;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    DOWN:    counter <= counter - 1'b1;
                    default: dir <= UP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_pwm.sv
// Self-checking bench for multi_channel_pwm: directed scenarios plus random
// stimulus, all cycles compared against a tick-index reference model.
module tb_multi_channel_pwm;

    localparam int unsigned RES = 8;
    localparam int unsigned CH  = 4;
    localparam int unsigned CB  = 2;
    localparam int unsigned PW  = 8;

    logic           clk;
    logic           reset;
    logic           enable;
    logic           mode;
    logic [PW-1:0]  prescale;
    logic [RES-1:0] period;
    logic           wr_en;
    logic [CB-1:0]  wr_chan;
    logic [RES-1:0] wr_duty;
    logic [CH-1:0]  pulse;
    logic [RES-1:0] counter;
    logic           period_start;

    int n_checks = 0;
    int n_fail   = 0;

    multi_channel_pwm #(
        .RESOLUTION(RES), .CHANNELS(CH), .CHAN_BITS(CB), .PRESCALE_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .prescale(prescale), .period(period), .wr_en(wr_en),
        .wr_chan(wr_chan), .wr_duty(wr_duty), .pulse(pulse),
        .counter(counter), .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the period as a plain tick index.
    int             m_psc;
    int             m_phase;
    int             m_per;
    bit             m_mode;
    int             m_duty [CH];
    int             m_pend [CH];
    logic [CH-1:0]  exp_pulse;
    logic           exp_ps;
    logic [RES-1:0] exp_counter;

    function automatic int pos_to_count(input int ph, input int p);
        return (ph <= p) ? ph : 2 * p - ph;
    endfunction

    function automatic int period_len(input int p, input bit m);
        if (p == 0) return 1;
        return m ? 2 * p : p + 1;
    endfunction

    assign exp_counter = RES'(pos_to_count(m_phase, m_per));

    always @(posedge clk or posedge reset) begin
        int cnt;
        bit tk;
        bit bnd;
        if (reset) begin
            m_psc   <= 0;
            m_phase <= 0;
            m_per   <= 0;
            m_mode  <= 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                m_duty[i] <= 0;
                m_pend[i] <= 0;
            end
            exp_pulse <= '0;
            exp_ps    <= 1'b0;
        end else begin
            cnt = pos_to_count(m_phase, m_per);
            if (!enable) begin
                m_psc     <= 0;
                m_phase   <= 0;
                m_per     <= int'(period);
                m_mode    <= mode;
                m_duty    <= m_pend;
                exp_pulse <= '0;
                exp_ps    <= 1'b0;
            end else begin
                for (int i = 0; i < int'(CH); i++)
                    exp_pulse[i] <= (m_duty[i] != 0) && (cnt < m_duty[i]);
                tk  = m_psc >= int'(prescale);
                bnd = tk && (m_phase == period_len(m_per, m_mode) - 1);
                exp_ps <= bnd;
                m_psc  <= tk ? 0 : m_psc + 1;
                if (tk) m_phase <= bnd ? 0 : m_phase + 1;
                if (bnd) begin
                    m_per  <= int'(period);
                    m_mode <= mode;
                    m_duty <= m_pend;
                end
            end
            if (wr_en) m_pend[int'(wr_chan)] <= int'(wr_duty);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input bit m, input int p, input int ps);
        enable   = 1'b0;
        mode     = m;
        period   = RES'(p);
        prescale = PW'(ps);
        step();
        step();
    endtask

    task automatic write_duty(input int ch, input int d);
        wr_en   = 1'b1;
        wr_chan = CB'(ch);
        wr_duty = RES'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #23;
        n_checks++;
        if (counter !== '0 || pulse !== '0 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: counter=%0d pulse=%b ps=%b, required 0/0000/0", counter, pulse, period_start);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (counter !== '0 || pulse !== '0 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: counter=%0d pulse=%b ps=%b, required 0/0000/0", counter, pulse, period_start);
        end
    endtask

    task automatic test_edge_basic();
        int h[CH];
        int psn;
        int ps_first;
        int ps_last;
        int exp_h[CH] = '{6, 0, 20, 20};
        h = '{default: 0};
        psn = 0; ps_first = -1; ps_last = -1;
        configure(1'b0, 9, 0);
        write_duty(0, 3); write_duty(1, 0); write_duty(2, 10); write_duty(3, 255);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL edge_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            for (int i = 0; i < int'(CH); i++) h[i] += int'(pulse[i]);
            if (period_start) begin
                psn++;
                if (ps_first < 0) ps_first = k;
                ps_last = k;
            end
        end
        for (int i = 0; i < int'(CH); i++) begin
            n_checks++;
            if (h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL edge_high_count ch%0d: %0d high of 20, required %0d", i, h[i], exp_h[i]);
            end
        end
        n_checks++;
        if (psn !== 2 || ps_last - ps_first !== 10) begin
            n_fail++;
            $display("FAIL edge_period_start: %0d strobes spacing %0d, required 2 spacing 10", psn, ps_last - ps_first);
        end
    endtask

    task automatic test_prescale();
        int h0, psn, c0, c4;
        h0 = 0; psn = 0; c0 = 0; c4 = 0;
        configure(1'b0, 4, 3);
        write_duty(0, 2);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL prescale_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            if (k > 20) begin
                h0  += int'(pulse[0]);
                psn += int'(period_start);
                if (counter == 8'd0) c0++;
                if (counter == 8'd4) c4++;
            end
        end
        n_checks++;
        if (h0 !== 8 || psn !== 1) begin
            n_fail++;
            $display("FAIL prescale_duty: high=%0d strobes=%0d in 20 clks, required 8 and 1", h0, psn);
        end
        n_checks++;
        if (c0 !== 4 || c4 !== 4) begin
            n_fail++;
            $display("FAIL prescale_hold: counter 0 held %0d, 4 held %0d clks, required 4 and 4", c0, c4);
        end
    endtask

    task automatic test_center();
        int h0, psn, p, expc;
        h0 = 0; psn = 0;
        configure(1'b1, 8, 0);
        write_duty(0, 3);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            p    = k % 16;
            expc = (p <= 8) ? p : 16 - p;
            n_checks++;
            if (int'(counter) !== expc) begin
                n_fail++;
                $display("FAIL center_sequence @%0t: counter %0d, required %0d", $time, counter, expc);
            end
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL center_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            h0  += int'(pulse[0]);
            psn += int'(period_start);
        end
        n_checks++;
        if (h0 !== 10 || psn !== 2) begin
            n_fail++;
            $display("FAIL center_duty: high=%0d strobes=%0d in 32 clks, required 10 and 2", h0, psn);
        end
    endtask

    task automatic test_mid_write();
        int h[4];
        int exp_h[4] = '{3, 7, 7, 2};
        bit w1, w2;
        h = '{default: 0};
        w1 = 1'b0; w2 = 1'b0;
        configure(1'b0, 9, 0);
        write_duty(0, 3);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            wr_en = 1'b0;
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL mid_write_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            h[(k - 1) / 10] += int'(pulse[0]);
            if (!w1 && k < 10 && counter == 8'd5) begin
                wr_en = 1'b1; wr_chan = 2'd0; wr_duty = 8'd7; w1 = 1'b1;
            end
            if (!w2 && k > 10 && k < 20 && counter == 8'd9) begin
                wr_en = 1'b1; wr_chan = 2'd0; wr_duty = 8'd2; w2 = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL mid_write_period%0d: %0d high ticks, required %0d", i, h[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        int ps_idx[$];
        int maxc, c9;
        maxc = 0; c9 = -1;
        configure(1'b0, 9, 0);
        write_duty(0, 3);
        step();
        enable = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL mode_change_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            if (period_start) ps_idx.push_back(k);
            if (k == 9) c9 = int'(counter);
            if (k > 10 && k <= 20 && int'(counter) > maxc) maxc = int'(counter);
            if (k == 5) begin
                mode   = 1'b1;
                period = 8'd5;
            end
        end
        n_checks++;
        if (c9 !== 9) begin
            n_fail++;
            $display("FAIL mode_change_deferred: counter %0d before boundary, required 9", c9);
        end
        n_checks++;
        if (ps_idx.size() < 2) begin
            n_fail++;
            $display("FAIL mode_change_strobes: %0d strobes, required at least 2", ps_idx.size());
        end else begin
            n_checks++;
            if (ps_idx[0] !== 10 || ps_idx[1] !== 20) begin
                n_fail++;
                $display("FAIL mode_change_period: strobes at %0d,%0d, required 10,20", ps_idx[0], ps_idx[1]);
            end
        end
        n_checks++;
        if (maxc !== 5) begin
            n_fail++;
            $display("FAIL mode_change_top: peak counter %0d, required 5", maxc);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        configure(1'b0, 9, 0);
        write_duty(0, 8);
        step();
        enable = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL async_reset_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            if (counter == 8'd6) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL async_reset_wait: counter never reached 6, last %0d", counter);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (counter !== '0 || pulse !== '0 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_clear: counter=%0d pulse=%b ps=%b, required 0/0000/0", counter, pulse, period_start);
        end
        #2;
        reset = 1'b0;
        step();
        n_checks++;
        if (period_start !== 1'b1 || counter !== '0) begin
            n_fail++;
            $display("FAIL async_reset_first_tick: ps=%b counter=%0d, required 1 and 0", period_start, counter);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps} || pulse !== '0) begin
                n_fail++;
                $display("FAIL async_reset_after @%0t: got %0d/%b/%b required %0d/0000/%b", $time, counter, pulse, period_start, exp_counter, exp_ps);
            end
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 800; k++) begin
            step();
            n_checks++;
            if ({counter, pulse, period_start} !== {exp_counter, exp_pulse, exp_ps}) begin
                n_fail++;
                $display("FAIL random_model @%0t: got %0d/%b/%b required %0d/%b/%b", $time, counter, pulse, period_start, exp_counter, exp_pulse, exp_ps);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_chan = CB'($urandom_range(0, 3));
            wr_duty = RES'($urandom_range(0, 18));
            if ($urandom_range(0, 39) == 0) begin
                mode   = 1'($urandom_range(0, 1));
                period = RES'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 59) == 0) begin
                enable = ~enable;
                if (!enable) prescale = PW'($urandom_range(0, 2));
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        enable   = 1'b0;
        mode     = 1'b0;
        prescale = '0;
        period   = '0;
        wr_en    = 1'b0;
        wr_chan  = '0;
        wr_duty  = '0;
        test_reset();
        test_edge_basic();
        test_prescale();
        test_center();
        test_mid_write();
        test_mode_change();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
